// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder
// Takes one decoded Y86-64 instruction per handshake and writes its byte
// encoding into instruction memory, one byte per cycle, starting at the
// current write pointer. The write pointer advances past each instruction
// and can be reloaded from i_base_addr while the encoder is idle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for an instruction or a base-address load
// S_EMIT | presenting the bytes of the accepted instruction, one per cycle

module y86_instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_base_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_icode,
    input  logic [3:0]        i_ifun,
    input  logic [3:0]        i_ra,
    input  logic [3:0]        i_rb,
    input  logic [63:0]       i_valc,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_instr_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_next_addr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // One past the last legal byte address, at ADDR_W+1 bits.
    localparam logic [ADDR_W:0] MEM_SIZE = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] ERR_ICODE    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    // Encoded length in bytes; 0 marks an icode with no encoding.
    function automatic logic [3:0] f_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            4'h0, 4'h1, 4'h9:         len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:   len = 4'd2;
            4'h3, 4'h4, 4'h5:         len = 4'd10;
            4'h7, 4'h8:               len = 4'd9;
            default:                  len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic f_has_reg(input logic [3:0] icode);
        logic has;
        case (icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has = 1'b1;
            default:                                  has = 1'b0;
        endcase
        return has;
    endfunction

    // Byte k of the encoding. irmovq has no source register and push/pop
    // have no rB, so those nibbles are forced to F (the "no register" id).
    function automatic logic [7:0] f_byte(
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] valc,
        input logic [3:0]  k
    );
        logic [3:0] ra_f;
        logic [3:0] rb_f;
        logic [2:0] j;
        logic [7:0] b;
        ra_f = (icode == 4'h3) ? 4'hF : ra;
        rb_f = (icode == 4'hA || icode == 4'hB) ? 4'hF : rb;
        j    = f_has_reg(icode) ? 3'(k - 4'd2) : 3'(k - 4'd1);
        if (k == 4'd0)
            b = {icode, ifun};
        else if (f_has_reg(icode) && k == 4'd1)
            b = {ra_f, rb_f};
        else
            b = valc[{j, 3'b000} +: 8];
        return b;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_next_addr;
    logic [3:0]         r_icode;
    logic [3:0]         r_ifun;
    logic [3:0]         r_ra;
    logic [3:0]         r_rb;
    logic [63:0]        r_valc;
    logic [3:0]         r_len;
    logic [3:0]         r_idx;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_instr_done;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_in_ready;
    logic               w_busy;
    logic [3:0]         w_len_in;
    logic               w_invalid_in;
    logic [ADDR_W:0]    w_end_in;
    logic               w_ovf_in;
    logic               w_accept;
    logic               w_start;
    logic               w_last;
    logic [3:0]         w_idx_nxt;
    logic [7:0]         w_byte0_in;
    logic [7:0]         w_byte_nxt;

    assign w_len_in     = f_len(i_icode);
    assign w_invalid_in = (w_len_in == 4'd0);
    assign w_end_in     = {1'b0, r_next_addr} + (ADDR_W+1)'(w_len_in);
    assign w_ovf_in     = (w_end_in > MEM_SIZE);
    assign w_accept     = i_in_valid & w_in_ready;
    assign w_start      = w_accept & ~w_invalid_in & ~w_ovf_in;
    assign w_last       = (r_idx == r_len - 4'd1);
    assign w_idx_nxt    = r_idx + 4'd1;
    assign w_byte0_in   = f_byte(i_icode, i_ifun, i_ra, i_rb, i_valc, 4'd0);
    assign w_byte_nxt   = f_byte(r_icode, r_ifun, r_ra, r_rb, r_valc, w_idx_nxt);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: enter EMIT only for a legal, fitting instruction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; a pending base load blocks the handshake.
    always_comb begin
        w_in_ready = (r_state == S_IDLE) & ~i_base_load & ~i_reset;
        w_busy     = (r_state == S_EMIT);
    end

    // Datapath: field capture, byte sequencing, write pointer and error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_next_addr  <= '0;
            r_icode      <= '0;
            r_ifun       <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_valc       <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_instr_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_base_load) begin
                        r_next_addr <= i_base_addr;
                    end else if (w_accept) begin
                        r_icode <= i_icode;
                        r_ifun  <= i_ifun;
                        r_ra    <= i_ra;
                        r_rb    <= i_rb;
                        r_valc  <= i_valc;
                        r_len   <= w_len_in;
                        r_idx   <= 4'd0;
                        if (w_invalid_in) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_ICODE;
                        end else if (w_ovf_in) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_OVERFLOW;
                        end else begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_next_addr;
                            r_wr_data    <= w_byte0_in;
                            r_instr_done <= (w_len_in == 4'd1);
                        end
                    end
                end
                S_EMIT: begin
                    if (w_last) begin
                        // Address and data keep the final byte's values.
                        r_wr_en      <= 1'b0;
                        r_instr_done <= 1'b0;
                        r_next_addr  <= r_next_addr + ADDR_W'(r_len);
                    end else begin
                        r_idx        <= w_idx_nxt;
                        r_wr_addr    <= r_wr_addr + 1'b1;
                        r_wr_data    <= w_byte_nxt;
                        r_instr_done <= (w_idx_nxt == r_len - 4'd1);
                    end
                end
                default: begin
                    r_wr_en      <= 1'b0;
                    r_instr_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_busy       = w_busy;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_instr_done = r_instr_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_next_addr  = r_next_addr;

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Write-side counterpart to the Fetch stage.
- Accepts one decoded Y86-64 instruction per handshake (icode, ifun, rA, rB, valC) and serialises it into the byte encoding that Fetch parses.
- Writes one byte per cycle into instruction memory at an auto-incrementing address.
- Used by benches and program loaders to build Instruction_memory images, replacing hand-written byte lists.

Parameters:
ADDR_W, 10, width of the byte address; the memory holds 2^ADDR_W bytes (1024 by default, matching the Fetch pcvalid limit).

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
base_load  input  1  load base_addr into the write pointer (honoured in IDLE only)
base_addr  input  ADDR_W  new write pointer value
in_valid  input  1  instruction fields are valid
in_ready  output  1  encoder can accept an instruction
icode  input  4  instruction code
ifun  input  4  function code
rA  input  4  register A
rB  input  4  register B
valC  input  64  constant, displacement or destination
wr_en  output  1  byte write strobe
wr_addr  output  ADDR_W  byte address
wr_data  output  8  byte value
busy  output  1  high while in EMIT
instr_done  output  1  one-cycle pulse with the last byte of an instruction
err  output  1  one-cycle pulse when an accepted instruction is rejected
err_code  output  2  1 = invalid icode, 2 = memory overflow; holds its value until the next err
next_addr  output  ADDR_W  current write pointer (the PC of the next instruction)

Behaviour:
- Reset values: in_ready=0 during reset; wr_en=0, wr_addr=0, wr_data=0, busy=0, instr_done=0, err=0, err_code=0, next_addr=0; state=IDLE.
- in_ready = (state==IDLE) & ~base_load & ~reset.
- base_load in IDLE: next_addr <= base_addr; it takes priority over in_valid in the same cycle. base_load in EMIT is ignored.
- Accept occurs on the edge where in_valid & in_ready. The encoder latches all fields and length L, chosen by icode:
  - 0 halt, 1 nop, 9 ret: L=1
  - 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: L=2
  - 3 irmovq, 4 rmmovq, 5 mrmovq: L=10
  - 7 jXX, 8 call: L=9
  - icode C..F: invalid
- Byte stream:
  - Byte0 = {icode, ifun}.
  - Register byte, when present, = {rA, rB}, with forced fields: irmovq rA=F; pushq and popq rB=F.
  - valC follows the register byte (or byte0 for jXX/call), little-endian, LSB first, 8 bytes.
  - ifun is passed through unchecked.
- Invalid icode: no writes, err=1 and err_code=1 on the cycle after accept, next_addr unchanged, state stays IDLE.
- Overflow: if next_addr + L > 2^ADDR_W (computed at ADDR_W+1 bits), no writes, err=1 and err_code=2 on the cycle after accept, next_addr unchanged. An instruction ending exactly at address 2^ADDR_W-1 is legal.
- EMIT timing: accept at edge N → byte k (k=0..L-1) is presented with wr_en=1, wr_addr=base+k, wr_data=byte k during cycle N+1+k.
  - instr_done=1 with byte L-1.
  - next_addr becomes base+L at the edge ending the last byte.
  - State returns to IDLE; in_ready is high again in cycle N+L+1, so throughput is L+1 cycles per instruction.
- wr_en is never high outside EMIT. wr_data and wr_addr hold their last values when wr_en=0.
- Reset during EMIT aborts the stream: no further writes from the next cycle onward, partial bytes stay in memory, next_addr=0.
- Inputs are ignored while in_ready=0. Fields may change after accept.

Test Plan:
1. Reset, then nop (icode=1, ifun=0) → one write: addr 0, data 0x10; instr_done in the same cycle; next_addr=1.
2. rrmovq (icode=2, rA=0, rB=1) → addr1=0x20, addr2=0x01, written in consecutive cycles. Then irmovq (rA=5, rB=2, valC=0x0123456789ABCDEF) → addr3..12 = 30 F2 EF CD AB 89 67 45 23 01 (rA forced to F); next_addr=13; in_ready low for 10 cycles.
3. base_load with base_addr=100, then call (icode=8, valC=0x21) → addr100=0x80, addr101=0x21, addr102..108=0x00; next_addr=109. Then pushq (rA=3, rB=0) → 0xA0, 0x3F.
4. Invalid icode 0xC at next_addr=5 → no wr_en, err=1, err_code=1, next_addr stays 5, in_ready high the following cycle.
5. base_addr=1015, irmovq (L=10) → err_code=2, no writes. With base_addr=1014, same instruction → writes 1014..1023, next_addr wraps to 0.
6. Reset asserted on the 4th byte of an irmovq → at most 3 bytes written, wr_en=0 from the next cycle, next_addr=0; base_load asserted while busy is ignored; base_load together with in_valid in IDLE → load happens and the instruction is not accepted.
